// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// pipeline writeback stage (WB, priority) and a multi-cycle execution unit (MC).
// MC results wait in a 2-entry FIFO; a starvation counter forces an MC slot
// after STARVE_LIMIT consecutive WB grants while MC has a pending entry.
// All rf_* outputs come straight from registers.
module rf_write_arbiter #(
   parameter int WORD_LEN     = 32,
   parameter int ADDR_LEN     = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_valid,
   input  logic [ADDR_LEN-1:0] wb_dest,
   input  logic [WORD_LEN-1:0] wb_val,
   output logic                wb_ready,
   input  logic                mc_valid,
   input  logic [ADDR_LEN-1:0] mc_dest,
   input  logic [WORD_LEN-1:0] mc_val,
   output logic                mc_ready,
   output logic                rf_writeEn,
   output logic [ADDR_LEN-1:0] rf_dest,
   output logic [WORD_LEN-1:0] rf_writeVal,
   output logic                grant_src,
   output logic [1:0]          mc_count
);

   typedef enum logic {
      WB_PRI   = 1'b0,
      MC_FORCE = 1'b1
   } state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   // Arbiter state
   state_t        state_q, state_d;
   logic [2:0]    starve_q, starve_d;

   // MC FIFO: two slots addressed by 1-bit read/write pointers
   logic [ADDR_LEN-1:0] fifo_dest_q [2];
   logic [WORD_LEN-1:0] fifo_val_q  [2];
   logic                rd_ptr_q, rd_ptr_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic [1:0]          count_q, count_d;
   logic [ADDR_LEN-1:0] head_dest;
   logic [WORD_LEN-1:0] head_val;

   // Write-out registers
   logic                rf_we_q, rf_we_d;
   logic [ADDR_LEN-1:0] rf_dest_q, rf_dest_d;
   logic [WORD_LEN-1:0] rf_val_q, rf_val_d;
   logic                src_q, src_d;

   // Per-cycle decisions
   logic push;
   logic grant_wb;
   logic grant_mc;

   // Handshakes depend only on reset, state and occupancy, never on the valids.
   assign wb_ready  = !rst && (state_q == WB_PRI);
   assign mc_ready  = !rst && (count_q != 2'd2);
   assign push      = mc_valid && mc_ready;
   assign head_dest = fifo_dest_q[rd_ptr_q];
   assign head_val  = fifo_val_q[rd_ptr_q];

   // Arbitration, starvation counting and next FSM state.
   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      grant_wb = 1'b0;
      grant_mc = 1'b0;

      if (!rst) begin
         unique case (state_q)
            WB_PRI: begin
               if (wb_valid) begin
                  grant_wb = 1'b1;
               end else if (count_q != 2'd0) begin
                  grant_mc = 1'b1;
               end
            end
            MC_FORCE: begin
               // Entering MC_FORCE needs a pending entry and nothing pops in
               // that cycle, so the FIFO is never empty here.
               grant_mc = (count_q != 2'd0);
               state_d  = WB_PRI;
            end
            default: state_d = WB_PRI;
         endcase

         if (grant_mc || (count_q == 2'd0)) begin
            starve_d = 3'd0;
         end else if (grant_wb && (starve_q < LIMIT)) begin
            starve_d = starve_q + 3'd1;
            if (starve_q + 3'd1 == LIMIT) begin
               state_d = MC_FORCE;
            end
         end
      end
   end

   // FIFO pointer and occupancy update; a simultaneous pop and push leaves the
   // count unchanged (pop takes the old head, push goes to the tail).
   always_comb begin
      rd_ptr_d = rd_ptr_q ^ grant_mc;
      wr_ptr_d = wr_ptr_q ^ push;
      unique case ({push, grant_mc})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Next write-out value: granted request, with r0 writes consumed but
   // suppressed; with no grant only the enable drops.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_dest_d = rf_dest_q;
      rf_val_d  = rf_val_q;
      src_d     = src_q;
      if (grant_wb) begin
         rf_we_d   = (wb_dest != '0);
         rf_dest_d = wb_dest;
         rf_val_d  = wb_val;
         src_d     = 1'b0;
      end else if (grant_mc) begin
         rf_we_d   = (head_dest != '0);
         rf_dest_d = head_dest;
         rf_val_d  = head_val;
         src_d     = 1'b1;
      end
   end

   // Control and write-out registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WB_PRI;
         starve_q  <= 3'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         rf_we_q   <= 1'b0;
         rf_dest_q <= '0;
         rf_val_q  <= '0;
         src_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         rf_we_q   <= rf_we_d;
         rf_dest_q <= rf_dest_d;
         rf_val_q  <= rf_val_d;
         src_q     <= src_d;
      end
   end

   // FIFO payload storage, written on push.
   // NOTE: the payload array is deliberately not reset; the cleared count and
   // pointers already mark every slot empty, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dest_q[wr_ptr_q] <= mc_dest;
         fifo_val_q[wr_ptr_q]  <= mc_val;
      end
   end

   assign rf_writeEn  = rf_we_q;
   assign rf_dest     = rf_dest_q;
   assign rf_writeVal = rf_val_q;
   assign grant_src   = src_q;
   assign mc_count    = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a queue-based reference model is
// compared against every output on each negedge, with directed scenarios
// carrying hand-computed expectations followed by a randomized run.
module tb_rf_write_arbiter;

   localparam int WORD_LEN     = 32;
   localparam int ADDR_LEN     = 5;
   localparam int STARVE_LIMIT = 4;

   logic                clk;
   logic                rst;
   logic                wb_valid;
   logic [ADDR_LEN-1:0] wb_dest;
   logic [WORD_LEN-1:0] wb_val;
   logic                wb_ready;
   logic                mc_valid;
   logic [ADDR_LEN-1:0] mc_dest;
   logic [WORD_LEN-1:0] mc_val;
   logic                mc_ready;
   logic                rf_writeEn;
   logic [ADDR_LEN-1:0] rf_dest;
   logic [WORD_LEN-1:0] rf_writeVal;
   logic                grant_src;
   logic [1:0]          mc_count;

   rf_write_arbiter #(
      .WORD_LEN    (WORD_LEN),
      .ADDR_LEN    (ADDR_LEN),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb_valid),
      .wb_dest    (wb_dest),
      .wb_val     (wb_val),
      .wb_ready   (wb_ready),
      .mc_valid   (mc_valid),
      .mc_dest    (mc_dest),
      .mc_val     (mc_val),
      .mc_ready   (mc_ready),
      .rf_writeEn (rf_writeEn),
      .rf_dest    (rf_dest),
      .rf_writeVal(rf_writeVal),
      .grant_src  (grant_src),
      .mc_count   (mc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit run    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [ADDR_LEN-1:0] dest;
      logic [WORD_LEN-1:0] val;
   } entry_t;

   entry_t              q[$];
   int                  starve  = 0;
   bit                  force_mc = 1'b0;
   bit                  m_we    = 1'b0;
   logic [ADDR_LEN-1:0] m_dest  = '0;
   logic [WORD_LEN-1:0] m_val   = '0;
   bit                  m_src   = 1'b0;

   // Compare DUT against the model, then advance the model by one clock
   // using the inputs that will be sampled at the coming posedge.
   always @(negedge clk) begin : compare
      int     old_n;
      bit     g_wb;
      bit     g_mc;
      entry_t g;
      if (run) begin
         check("wb_ready",    wb_ready,    !rst && !force_mc);
         check("mc_ready",    mc_ready,    !rst && (q.size() < 2));
         check("mc_count",    mc_count,    q.size());
         check("rf_writeEn",  rf_writeEn,  m_we);
         check("rf_dest",     rf_dest,     m_dest);
         check("rf_writeVal", rf_writeVal, m_val);
         check("grant_src",   grant_src,   m_src);

         if (rst) begin
            q.delete();
            starve   = 0;
            force_mc = 1'b0;
            m_we     = 1'b0;
            m_dest   = '0;
            m_val    = '0;
            m_src    = 1'b0;
         end else begin
            old_n = q.size();
            g_wb  = 1'b0;
            g_mc  = 1'b0;
            if (force_mc)      g_mc = (old_n > 0);
            else if (wb_valid) g_wb = 1'b1;
            else if (old_n > 0) g_mc = 1'b1;

            if (g_wb) begin
               m_we = (wb_dest != 0); m_dest = wb_dest; m_val = wb_val; m_src = 1'b0;
            end else if (g_mc) begin
               g = q.pop_front();
               m_we = (g.dest != 0); m_dest = g.dest; m_val = g.val; m_src = 1'b1;
            end else begin
               m_we = 1'b0;
            end

            if (g_mc || old_n == 0) starve = 0;
            else if (g_wb)          starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
            force_mc = g_wb && (old_n > 0) && (starve == STARVE_LIMIT);

            // Push is judged against the pre-pop occupancy: no bypass.
            if (mc_valid && old_n < 2) q.push_back('{mc_dest, mc_val});
         end
      end
   end

   // Drive one cycle of inputs, then return just after the sampling edge.
   task automatic step(input bit r, input bit wv, input logic [ADDR_LEN-1:0] wd,
                       input logic [WORD_LEN-1:0] wvl, input bit mv,
                       input logic [ADDR_LEN-1:0] md, input logic [WORD_LEN-1:0] mvl);
      rst = r; wb_valid = wv; wb_dest = wd; wb_val = wvl;
      mc_valid = mv; mc_dest = md; mc_val = mvl;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with both valids high.
      step(1, 1, 5'd7, 32'h1234, 1, 5'd8, 32'h5678);
      run = 1'b1;
      step(1, 1, 5'd7, 32'h1234, 1, 5'd8, 32'h5678);
      check("rst wb_ready",    wb_ready,    0);
      check("rst mc_ready",    mc_ready,    0);
      check("rst rf_writeEn",  rf_writeEn,  0);
      check("rst rf_dest",     rf_dest,     0);
      check("rst rf_writeVal", rf_writeVal, 0);
      check("rst grant_src",   grant_src,   0);
      check("rst mc_count",    mc_count,    0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("post-rst wb_ready", wb_ready, 1);
      check("post-rst mc_ready", mc_ready, 1);

      // Single WB write.
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      check("wb rf_writeEn",  rf_writeEn,  1);
      check("wb rf_dest",     rf_dest,     5);
      check("wb rf_writeVal", rf_writeVal, 32'hDEADBEEF);
      check("wb grant_src",   grant_src,   0);

      // Starvation: WB always valid, MC pushes two entries.
      step(0, 1, 5'd10, 32'h1, 1, 5'd3, 32'h11);
      step(0, 1, 5'd10, 32'h2, 1, 5'd4, 32'h22);
      check("starve full mc_count", mc_count, 2);
      check("starve full mc_ready", mc_ready, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 5'd10, 32'h3 + i, 0, 0, 0);
      check("forced wb_ready", wb_ready, 0);
      step(0, 1, 5'd10, 32'h9, 0, 0, 0);
      check("forced rf_dest",     rf_dest,     3);
      check("forced rf_writeVal", rf_writeVal, 32'h11);
      check("forced grant_src",   grant_src,   1);
      check("forced rf_writeEn",  rf_writeEn,  1);
      check("after force wb_ready", wb_ready, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 5'd10, 32'h20 + i, 0, 0, 0);
      check("second force wb_ready", wb_ready, 0);
      step(0, 1, 5'd10, 32'h30, 0, 0, 0);
      check("second rf_dest",     rf_dest,     4);
      check("second rf_writeVal", rf_writeVal, 32'h22);
      check("second grant_src",   grant_src,   1);
      check("second mc_count",    mc_count,    0);

      // r0 suppression.
      check("r0 wb_ready", wb_ready, 1);
      step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
      check("r0 rf_writeEn", rf_writeEn, 0);
      check("r0 rf_dest",    rf_dest,    0);

      // Push/pop at full with WB idle.
      step(0, 1, 5'd9, 32'h90, 1, 5'd1, 32'hA1);
      step(0, 1, 5'd9, 32'h91, 1, 5'd2, 32'hA2);
      check("fill mc_count", mc_count, 2);
      step(0, 0, 0, 0, 1, 5'd6, 32'hA3);
      check("full pop mc_count", mc_count, 1);
      check("full pop rf_dest",  rf_dest,  1);
      check("full pop src",      grant_src, 1);
      step(0, 0, 0, 0, 1, 5'd6, 32'hA3);
      check("push+pop mc_count", mc_count, 1);
      check("push+pop rf_dest",  rf_dest,  2);
      step(0, 0, 0, 0, 0, 0, 0);
      check("drain rf_dest",     rf_dest,     6);
      check("drain rf_writeVal", rf_writeVal, 32'hA3);
      check("drain mc_count",    mc_count,    0);

      // Reset while full and in the forced-MC state.
      step(0, 1, 5'd13, 32'hC0, 1, 5'd11, 32'hB1);
      step(0, 1, 5'd13, 32'hC1, 1, 5'd12, 32'hB2);
      for (int i = 0; i < 3; i++) step(0, 1, 5'd13, 32'hC2 + i, 0, 0, 0);
      check("pre-rst wb_ready", wb_ready, 0);
      check("pre-rst mc_count", mc_count, 2);
      step(1, 1, 5'd13, 32'hCC, 0, 0, 0);
      check("mid-rst mc_count",   mc_count,   0);
      check("mid-rst rf_writeEn", rf_writeEn, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0);
         check("no stale MC write", rf_writeEn, 0);
      end
      check("after rst wb_ready", wb_ready, 1);
      check("after rst src",      grant_src, 0);

      // Randomized traffic with occasional resets; model checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0,
              (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
              ADDR_LEN'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) == 1,
              ADDR_LEN'($urandom_range(0, 31)), $urandom);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage (WB) and a multi-cycle execution unit (MC, e.g. mul/div). WB has priority. MC results queue in a 2-entry buffer, and a starvation counter guarantees MC a write slot. The block sits directly in front of the register file and drives its `writeEn`/`dest`/`writeVal` inputs from registers.

## Interface
- `WORD_LEN`, 32: data width.
- `ADDR_LEN`, 5: register address width.
- `STARVE_LIMIT`, 4: consecutive WB grants tolerated while MC has a pending entry.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `wb_valid` in 1: WB write request.
- `wb_dest` in ADDR_LEN: WB destination register.
- `wb_val` in WORD_LEN: WB write data.
- `wb_ready` out 1: WB request accepted this cycle when `wb_valid` is high; low stalls the pipeline.
- `mc_valid` in 1: MC write request.
- `mc_dest` in ADDR_LEN: MC destination register.
- `mc_val` in WORD_LEN: MC write data.
- `mc_ready` out 1: MC buffer has room.
- `rf_writeEn` out 1: register file write enable (registered).
- `rf_dest` out ADDR_LEN: register file write address (registered).
- `rf_writeVal` out WORD_LEN: register file write data (registered).
- `grant_src` out 1: source of the current `rf_*` write; 0 = WB, 1 = MC (registered).
- `mc_count` out 2: MC buffer occupancy, 0..2.

## Operation
- **MC buffer:** 2-entry FIFO of {dest, val}.
  - Push when `mc_valid && mc_ready`.
  - `mc_ready = !rst && mc_count < 2`. No bypass: a full buffer refuses pushes even in a pop cycle.
- **FSM states:** `WB_PRI` (reset state) and `MC_FORCE`.
- **WB_PRI:**
  - `wb_ready = !rst`.
  - If `wb_valid`, grant WB.
  - Else, if `mc_count > 0`, grant MC at the head, which pops.
  - Else, no grant.
- **MC_FORCE:**
  - `wb_ready = 0`.
  - Grant MC at the head, which pops.
  - Next state is `WB_PRI`.
- **Starvation counter** (3 bits, saturating at `STARVE_LIMIT`):
  - Increments on a WB grant while `mc_count > 0`.
  - Clears on any MC grant or when `mc_count == 0`.
  - When an increment makes it equal `STARVE_LIMIT`, the next state is `MC_FORCE`.
- **Write-out:** on a grant, the next posedge loads `rf_dest`, `rf_writeVal` and `grant_src`. `rf_writeEn` is set to 1 only if the granted dest ≠ 0; writes to r0 are consumed but suppressed. With no grant, `rf_writeEn` is 0 and `rf_dest`/`rf_writeVal` hold.
- **Same-cycle push and MC grant:** the pop takes the old head and the push goes to the tail; `mc_count` is unchanged.
- **Same dest from WB and MC in one cycle:** WB is written first and MC later; the later MC write wins. Write ordering for a shared dest is enforced upstream (hazard unit), not here.
- **Reset:**
  - FIFO empties; pending entries are discarded, including mid-operation.
  - Counter clears, state goes to `WB_PRI`.
  - `rf_writeEn = 0`, `rf_dest = 0`, `rf_writeVal = 0`, `grant_src = 0`, `mc_count = 0`.
  - `wb_ready = 0` and `mc_ready = 0` while `rst` is high.

## Timing
- **Latency:** request accepted at posedge N → `rf_writeEn` high during cycle N+1. The register file commits on the negedge inside N+1, so the value is readable from cycle N+2.
- **Throughput:** one write per cycle total.
- **Handshakes:** `wb_ready` and `mc_ready` are combinational from state and `mc_count` only, never from the `*_valid` inputs. No combinational path exists from any input to any `rf_*` output.
- **Fairness:** with WB continuously valid and MC pending, MC gets exactly 1 slot every `STARVE_LIMIT`+1 cycles. WB stalls exactly 1 cycle per forced slot.
- **Buffer pops:** an MC entry pushed at posedge N can be granted no earlier than the cycle after N, with the pop at posedge N+1.

## Test plan
- **Reset values:** hold `rst` 2 cycles with both valids high → all outputs 0, both readies 0, nothing written. Release → `wb_ready = 1`, `mc_ready = 1`.
- **Single WB write:** `wb_valid` with dest 5, val 0xDEADBEEF, MC idle → next cycle `rf_writeEn = 1`, `rf_dest = 5`, `rf_writeVal = 0xDEADBEEF`, `grant_src = 0`.
- **Starvation and MC ordering:** WB valid every cycle; MC pushes (3, 0x11) then (4, 0x22) → buffer full, `mc_ready = 0`.
  - After 4 WB grants, `wb_ready = 0` for 1 cycle, then `rf_dest = 3`, val 0x11, `grant_src = 1`.
  - Entry (4, 0x22) is written 5 cycles later.
- **r0 suppression:** WB write to dest 0 with val 0xFFFFFFFF → accepted (`wb_ready = 1`), `rf_writeEn` stays 0, `rf_dest = 0`.
- **Push/pop at full:** `mc_count = 2`, WB idle, `mc_valid` high → head popped, push refused, `mc_count` goes 2→1. The following cycle the push is accepted and `mc_count` stays 1.
- **Reset mid-operation:** `mc_count = 2`, FSM in `MC_FORCE`, assert `rst` for 1 cycle → `mc_count = 0`, state `WB_PRI`, no MC write ever appears.
